// File: rtl/caches_pkg.sv
// Shared cache/memory types for the arbiter slice.
// Imported by the interface, the timer and the arbiter top.
package caches_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC
  } arb_state_t;

  localparam int ARB_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/caches_if.sv
// Cache-to-controller bundle.
// The ctrl modport is the arbiter's view of both caches.
interface caches_if;
  import caches_pkg::*;

  logic   iREN;
  word_t  iaddr;
  logic   iwait;
  dword_t iload;
  logic   dREN;
  logic   dWEN;
  word_t  daddr;
  dword_t dstore;
  logic   dwait;
  dword_t dload;

  modport ctrl (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    output iwait, iload,
    output dwait, dload
  );

  modport cache (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    input  iwait, iload,
    input  dwait, dload
  );

endinterface

// File: rtl/arb_timer.sv
// Owned-cycle counter for the memory arbiter.
// expired flags the last cycle before TIMEOUT is reached.
module arb_timer
  import caches_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/memory_arbiter.sv
// Two-cache to single-RAM arbiter with fair tie-break.
// Aborts a grant that waits TIMEOUT cycles for ram_ready.
module memory_arbiter
  import caches_pkg::*;
#(
  parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
  input  logic   CLK,
  input  logic   nRST,
  input  logic   iREN,
  input  word_t  iaddr,
  output logic   iwait,
  output dword_t iload,
  input  logic   dREN,
  input  logic   dWEN,
  input  word_t  daddr,
  input  dword_t dstore,
  output logic   dwait,
  output dword_t dload,
  output logic   ram_ren,
  output logic   ram_wen,
  output word_t  ram_addr,
  output dword_t ram_store,
  input  dword_t ram_load,
  input  logic   ram_ready,
  output logic   mem_err
);

  caches_if cif ();

  assign cif.iREN   = iREN;
  assign cif.iaddr  = iaddr;
  assign cif.dREN   = dREN;
  assign cif.dWEN   = dWEN;
  assign cif.daddr  = daddr;
  assign cif.dstore = dstore;
  assign iwait      = cif.iwait;
  assign iload      = cif.iload;
  assign dwait      = cif.dwait;
  assign dload      = cif.dload;

  arb_state_t state_q, state_d;
  logic   last_d_q, last_d_d;
  word_t  addr_q, addr_d;
  dword_t store_q, store_d;
  logic   err_q, err_d;

  logic   dreq;
  logic   tmr_clr;
  logic   tmr_en;
  logic   tmr_exp;
  logic   ren_c;
  logic   wen_c;
  logic   iwait_c;
  logic   dwait_c;
  dword_t iload_c;
  dword_t dload_c;

  assign dreq = cif.dREN | cif.dWEN;

  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (CLK),
    .rst_n   (nRST),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    addr_d   = addr_q;
    store_d  = store_q;
    err_d    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    ren_c    = 1'b0;
    wen_c    = 1'b0;
    iwait_c  = 1'b1;
    dwait_c  = 1'b1;
    iload_c  = '0;
    dload_c  = '0;
    unique case (state_q)
      IDLE: begin
        // last_d_q set means the dcache yields a tie
        if (dreq && (!cif.iREN || !last_d_q)) begin
          state_d = DACC;
          addr_d  = cif.daddr;
          store_d = cif.dstore;
          tmr_clr = 1'b1;
        end else if (cif.iREN) begin
          state_d = IACC;
          addr_d  = cif.iaddr;
          tmr_clr = 1'b1;
        end
      end
      DACC: begin
        wen_c = cif.dWEN;
        ren_c = cif.dREN & ~cif.dWEN;
        if (!dreq) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          dwait_c  = 1'b0;
          dload_c  = ram_load;
          state_d  = IDLE;
          last_d_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_exp) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            last_d_d = 1'b1;
          end
        end
      end
      IACC: begin
        ren_c = cif.iREN;
        if (!cif.iREN) begin
          state_d = IDLE;
        end else if (ram_ready) begin
          iwait_c  = 1'b0;
          iload_c  = ram_load;
          state_d  = IDLE;
          last_d_d = 1'b0;
        end else begin
          tmr_en = 1'b1;
          if (tmr_exp) begin
            state_d  = IDLE;
            err_d    = 1'b1;
            last_d_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      addr_q   <= '0;
      store_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      err_q    <= err_d;
    end
  end

  assign cif.iwait = iwait_c;
  assign cif.dwait = dwait_c;
  assign cif.iload = iload_c;
  assign cif.dload = dload_c;
  assign ram_ren   = ren_c;
  assign ram_wen   = wen_c;
  assign ram_addr  = addr_q;
  assign ram_store = store_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed scoreboard bench for memory_arbiter.
// Runs with TIMEOUT=4 so the abort path is short.
module tb_memory_arbiter;
  import caches_pkg::*;

  logic   CLK = 1'b0;
  logic   nRST;
  logic   iREN;
  word_t  iaddr;
  logic   iwait;
  dword_t iload;
  logic   dREN;
  logic   dWEN;
  word_t  daddr;
  dword_t dstore;
  logic   dwait;
  dword_t dload;
  logic   ram_ren;
  logic   ram_wen;
  word_t  ram_addr;
  dword_t ram_store;
  dword_t ram_load;
  logic   ram_ready;
  logic   mem_err;

  memory_arbiter #(
    .TIMEOUT (4)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_ready (ram_ready),
    .mem_err   (mem_err)
  );

  always #5 CLK = ~CLK;

  localparam logic [1:0] EV_N = 2'd0;
  localparam logic [1:0] EV_D = 2'd1;
  localparam logic [1:0] EV_I = 2'd2;
  localparam logic [1:0] EV_E = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [63:0] data;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  owned;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag,
                       input logic obs,
                       input logic exp);
    chk(tag, {63'd0, obs}, {63'd0, exp});
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic push(input logic [1:0] k,
                      input logic [63:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic observe(input string tag);
    logic [1:0]  k;
    logic [63:0] d;
    ev_t e;
    if (mem_err) begin
      k = EV_E;
      d = '0;
    end else if (!dwait) begin
      k = EV_D;
      d = dload;
    end else if (!iwait) begin
      k = EV_I;
      d = iload;
    end else begin
      k = EV_N;
      d = '0;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.kind = EV_N;
      e.data = '0;
    end
    chk({tag, " kind"}, 64'(k), 64'(e.kind));
    chk({tag, " data"}, d, e.data);
  endtask

  task automatic check_idle(input string tag);
    chk_b({tag, " ren"}, ram_ren, 1'b0);
    chk_b({tag, " wen"}, ram_wen, 1'b0);
    chk_b({tag, " iwait"}, iwait, 1'b1);
    chk_b({tag, " dwait"}, dwait, 1'b1);
    chk({tag, " iload"}, iload, 64'd0);
    chk({tag, " dload"}, dload, 64'd0);
  endtask

  initial begin
    nRST      = 1'b0;
    iREN      = 1'b0;
    dREN      = 1'b0;
    dWEN      = 1'b0;
    iaddr     = '0;
    daddr     = '0;
    dstore    = '0;
    ram_ready = 1'b1;
    ram_load  = 64'hDEAD_BEEF_CAFE_F00D;

    repeat (2) @(posedge CLK);
    smp();
    check_idle("rst");
    chk("rst addr", 64'(ram_addr), 64'd0);
    chk("rst store", ram_store, 64'd0);
    chk_b("rst err", mem_err, 1'b0);
    ram_ready = 1'b0;
    nxt();
    nRST = 1'b1;

    // dcache read, ready on third owned cycle
    nxt();
    dREN  = 1'b1;
    daddr = 32'h100;
    push(EV_D, 64'hA5A5_A5A5_0000_0001);
    smp();
    chk_b("t1 idle ren", ram_ren, 1'b0);
    nxt();
    smp();
    chk_b("t1 ren", ram_ren, 1'b1);
    chk("t1 addr", 64'(ram_addr), 64'h100);
    chk_b("t1 dwait c1", dwait, 1'b1);
    chk("t1 dload c1", dload, 64'd0);
    nxt();
    smp();
    chk_b("t1 dwait c2", dwait, 1'b1);
    nxt();
    ram_ready = 1'b1;
    ram_load  = 64'hA5A5_A5A5_0000_0001;
    smp();
    observe("t1 done");
    nxt();
    dREN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    check_idle("t1 after");

    // write wins over read
    nxt();
    dREN   = 1'b1;
    dWEN   = 1'b1;
    dstore = 64'h1234;
    daddr  = 32'h200;
    push(EV_D, 64'h5555_AAAA);
    smp();
    nxt();
    ram_ready = 1'b1;
    ram_load  = 64'h5555_AAAA;
    smp();
    chk_b("t2 wen", ram_wen, 1'b1);
    chk_b("t2 ren", ram_ren, 1'b0);
    chk("t2 store", ram_store, 64'h1234);
    chk("t2 addr", 64'(ram_addr), 64'h200);
    observe("t2 done");
    nxt();
    dREN      = 1'b0;
    dWEN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    check_idle("t2 after");

    // icache timeout abort and re-grant
    nxt();
    iREN  = 1'b1;
    iaddr = 32'h400;
    push(EV_E, 64'd0);
    smp();
    owned = 0;
    for (int i = 0; i < 10; i++) begin
      nxt();
      smp();
      if (mem_err) break;
      owned++;
      chk_b("t3 iwait", iwait, 1'b1);
    end
    chk("t3 owned", 64'(owned), 64'd4);
    observe("t3 err");
    chk_b("t3 idle ren", ram_ren, 1'b0);
    nxt();
    smp();
    chk_b("t3 regrant ren", ram_ren, 1'b1);
    chk_b("t3 err pulse", mem_err, 1'b0);
    chk("t3 regrant addr", 64'(ram_addr), 64'h400);

    // reset during IACC, then D/I alternation
    nxt();
    nRST      = 1'b0;
    ram_ready = 1'b1;
    dWEN      = 1'b1;
    daddr     = 32'h500;
    iaddr     = 32'h600;
    smp();
    check_idle("t4 rst");
    chk("t4 rst addr", 64'(ram_addr), 64'd0);
    chk_b("t4 rst err", mem_err, 1'b0);
    nxt();
    nRST = 1'b1;
    smp();
    check_idle("t4 idle");
    for (int g = 0; g < 4; g++) begin
      if (g % 2 == 0) push(EV_D, ram_load);
      else push(EV_I, ram_load);
      nxt();
      smp();
      observe("t4 grant");
      chk_b("t4 wen", ram_wen, (g % 2 == 0));
      chk_b("t4 ren", ram_ren, (g % 2 == 1));
      chk("t4 addr", 64'(ram_addr),
          (g % 2 == 0) ? 64'h500 : 64'h600);
      nxt();
      smp();
      check_idle("t4 gap");
    end

    // drop in DACC: strobes low, no completion
    nxt();
    iREN      = 1'b0;
    dWEN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    chk("t5 addr", 64'(ram_addr), 64'h500);
    chk_b("t5 wen", ram_wen, 1'b0);
    chk_b("t5 dwait", dwait, 1'b1);
    nxt();
    smp();
    check_idle("t5 idle");

    nxt();
    dREN  = 1'b1;
    daddr = 32'h700;
    smp();
    nxt();
    smp();
    chk_b("t6 ren", ram_ren, 1'b1);
    chk("t6 addr", 64'(ram_addr), 64'h700);
    nxt();
    dREN = 1'b0;
    smp();
    chk_b("t6 drop ren", ram_ren, 1'b0);
    chk_b("t6 drop wen", ram_wen, 1'b0);
    chk_b("t6 drop dwait", dwait, 1'b1);
    nxt();
    ram_ready = 1'b1;
    smp();
    check_idle("t6 idle");

    // drops left last-grant at icache: dcache wins tie
    nxt();
    ram_ready = 1'b0;
    dREN      = 1'b1;
    iREN      = 1'b1;
    daddr     = 32'h800;
    iaddr     = 32'h900;
    push(EV_D, 64'h77);
    smp();
    nxt();
    ram_ready = 1'b1;
    ram_load  = 64'h77;
    smp();
    observe("t7 tie");
    chk("t7 addr", 64'(ram_addr), 64'h800);
    chk_b("t7 iwait", iwait, 1'b1);
    nxt();
    dREN      = 1'b0;
    iREN      = 1'b0;
    ram_ready = 1'b0;
    smp();
    check_idle("t7 after");
    chk("sb empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles a grant waits for ram_ready before abort.
REQ-002 SHALL have port CLK  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous active-low reset.
REQ-004 SHALL have port iREN  input  1  icache read request.
REQ-005 SHALL have port iaddr  input  32 (word_t)  icache address.
REQ-006 SHALL have port iwait  output  1  icache stall; low exactly on the icache completion cycle.
REQ-007 SHALL have port iload  output  64  icache read data, valid when iwait low.
REQ-008 SHALL have ports dREN, dWEN  input  1 each  dcache read and write requests.
REQ-009 SHALL have ports daddr  input  32 (word_t) and dstore  input  64  dcache address and write data.
REQ-010 SHALL have ports dwait  output  1 and dload  output  64  dcache stall and read data.
REQ-011 SHALL have ports ram_ren, ram_wen  output  1 each  RAM strobes.
REQ-012 SHALL have ports ram_addr  output  32 and ram_store  output  64  RAM address and write data.
REQ-013 SHALL have ports ram_load  input  64 and ram_ready  input  1  RAM data and single-cycle completion.
REQ-014 SHALL have port mem_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-015 SHALL implement FSM states IDLE, DACC, IACC.
REQ-016 IDLE SHALL go to DACC if dREN|dWEN, else to IACC if iREN, else stay in IDLE.
REQ-017 When both caches request in IDLE, the grant SHALL go to the cache not granted last; after reset the dcache SHALL win.
REQ-018 On grant, SHALL latch the address, and dstore for a dcache grant, into registers driving ram_addr and ram_store.
REQ-019 In DACC, ram_wen SHALL equal dWEN and ram_ren SHALL equal dREN&~dWEN, so a write wins when both are high.
REQ-020 In IACC, ram_ren SHALL equal iREN and ram_wen SHALL be 0.
REQ-021 In IDLE, ram_ren and ram_wen SHALL be 0.
REQ-022 On the granted state's cycle with ram_ready=1, the owner's wait SHALL be 0 and its load SHALL equal ram_load combinationally; the FSM SHALL go to IDLE next cycle.
REQ-023 At all other times iwait and dwait SHALL be 1; iload and dload SHALL be 0 when their wait is high.
REQ-024 Minimum latency: request first high in cycle n, with ram_ready high in n+1, gives wait low in n+1.
REQ-025 If the owner drops its request while in DACC or IACC, SHALL deassert the RAM strobes that cycle and return to IDLE, with no wait-low cycle.
REQ-026 SHALL have a cycle counter that clears on grant and increments each owned cycle without ram_ready.
REQ-027 When the counter reaches TIMEOUT, SHALL return to IDLE, pulse mem_err for one cycle, and keep the owner's wait high so it re-arbitrates.
REQ-028 The last-grant bit SHALL update on completion and on timeout, but not on a dropped request.
REQ-029 ram_ready in IDLE SHALL be ignored.

Reset
REQ-030 While nRST=0: state=IDLE, counter=0, last-grant=icache so the dcache wins first; ram_addr=0, ram_store=0, ram_ren=0, ram_wen=0, mem_err=0, iwait=1, dwait=1, iload=0, dload=0.
REQ-031 Reset asserted mid-access SHALL abort immediately, with no completion and no mem_err.

Structure
REQ-032 arb_state_t (IDLE, DACC, IACC), word_t and ARB_TIMEOUT_DEFAULT SHALL reside in caches_pkg.
REQ-033 The cache-side ports SHALL bind to the existing caches_if interface through a controller-side modport.
REQ-034 One sub-module, arb_timer, SHALL hold the timeout counter with clear, enable and expired signals.

Verification
REQ-035 dREN=1, daddr=0x100, ram_ready on 3rd owned cycle, ram_load=0xA5A5_A5A5_0000_0001 -> ram_ren=1, ram_addr=0x100, dwait low one cycle, dload=0xA5A5_A5A5_0000_0001.
REQ-036 iREN and dWEN asserted together from reset, both held, ram_ready each cycle -> grant order D, I, D, I; ram_wen=1 on D grants; iwait and dwait alternate low.
REQ-037 dREN=dWEN=1, dstore=0x1234 -> ram_wen=1, ram_ren=0, ram_store=0x1234.
REQ-038 TIMEOUT=4, iREN held, ram_ready never -> mem_err pulses after 4 owned cycles, iwait stays 1, re-grant follows.
REQ-039 Grant in DACC, dREN dropped before ram_ready -> strobes low the same cycle, IDLE next cycle, dwait never low.
REQ-040 nRST pulsed low during IACC -> all outputs at reset values while low; first grant after release goes to the dcache.
